bcd_count_ctrl: RTL

BCD_COUNT_CTRL -- requirements
Module: bcd_count_ctrl

---
 rtl/bcd_count_ctrl_pkg.sv | 20 ++
 rtl/bcd_count_ctrl_digit.sv | 41 ++++
 rtl/bcd_count_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bcd_count_ctrl_pkg.sv
// Shared types and constants for the cascaded BCD counter controller.
// Holds the FSM state encoding, the decade limit and the default digit count.
package bcd_count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam int         NDIG_DEFAULT = 4;

    // Non-decimal nibbles are forced to zero so the counter never holds an illegal digit
    function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
        return (d > BCD_MAX) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_digit.sv
// One decade of the counter: clear/load/increment with a combinational carry to the next digit.
// Carry-out depends only on the incoming increment and the held value.
module bcd_digit
    import bcd_count_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry_out
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (ld) begin
            q_d = ld_val;
        end else if (inc) begin
            q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q         = q_q;
    assign carry_out = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/done controller around a chain of BCD digits, with target match and rollover pulses.
// Commands resolve clear > load > stop > start; tick only advances the count in RUN.
module bcd_count_ctrl
    import bcd_count_ctrl_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic [4*NDIG-1:0] target,
    input  logic              tick,
    output logic [4*NDIG-1:0] count,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic [1:0]        state
);

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;
    logic              inc_en;
    logic              dig_clr;
    logic              dig_ld;
    logic              carry_top;
    logic              target_ok;
    logic [4*NDIG-1:0] ld_val_s;
    logic [4*NDIG-1:0] cnt_inc;

    // Increment decision is kept apart from the FSM so the carry chain never loops back into it
    assign inc_en = (state_q == ST_RUN) && tick && !stop && !clear;

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        logic       cin;
        logic       cout;
        logic [3:0] q;

        if (gi == 0) begin : g_first
            assign cin = inc_en;
        end else begin : g_next
            assign cin = g_dig[gi-1].cout;
        end

        bcd_digit u_digit (
            .clk       (clk),
            .reset     (reset),
            .clr       (dig_clr),
            .ld        (dig_ld),
            .ld_val    (ld_val_s[4*gi +: 4]),
            .inc       (cin),
            .q         (q),
            .carry_out (cout)
        );

        assign count[4*gi +: 4]   = q;
        assign cnt_inc[4*gi +: 4] = cin ? ((q == BCD_MAX) ? 4'd0 : q + 4'd1) : q;
    end

    assign carry_top = g_dig[NDIG-1].cout;

    always_comb begin
        ld_val_s  = '0;
        target_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            ld_val_s[4*i +: 4] = bcd_sanitize(load_val[4*i +: 4]);
            if (target[4*i +: 4] > BCD_MAX) begin
                target_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dig_clr = 1'b0;
        dig_ld  = 1'b0;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clear) begin
            dig_clr = 1'b1;
            state_d = ST_IDLE;
        end else if (load && (state_q != ST_RUN)) begin
            dig_ld = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (inc_en) begin
                        wrap_d = carry_top;
                        if (target_ok && (cnt_inc == target)) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) state_d = ST_RUN;
                end
                ST_DONE: begin
                    if (start && !stop) begin
                        dig_clr = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;
    assign wrap  = wrap_q;
    assign state = state_q;

endmodule
